// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for the multi-channel bus timer
package timer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        DONE = 2'd3
    } state_t;
    typedef enum logic [2:0] {
        OFF_CTRL   = 3'd0,
        OFF_PRESET = 3'd1,
        OFF_COUNT  = 3'd2,
        OFF_CMP    = 3'd3,
        OFF_STATUS = 3'd4
    } reg_off_t;
    typedef enum logic [1:0] {
        M_ONESHOT    = 2'b00,
        M_RELOAD     = 2'b01,
        M_PWM        = 2'b10,
        M_RELOAD_ALT = 2'b11
    } mode_t;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IE   = 3;
    localparam int CTRL_PSC  = 4;
    localparam int PSC_W     = 8;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counter with prescaler, reload/pwm modes and W1C pending flag
module timer_channel
    import timer_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  off,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq,
    output logic        pwm
);
    logic             en, ie, pending, en_nxt, pend_nxt;
    mode_t            mode;
    logic [PSC_W-1:0] psc, psc_cnt, psc_nxt;
    logic [CW-1:0]    preset, cmp, count, count_nxt;
    state_t           state, state_nxt;

    // next state; a bus write to this channel freezes the counting machinery for that cycle
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        psc_nxt   = psc_cnt;
        pend_nxt  = pending;
        en_nxt    = en;
        if (we) begin
            pend_nxt = (off == OFF_STATUS && din[0]) ? 1'b0 : pending;
            en_nxt   = (off == OFF_CTRL) ? din[CTRL_EN] : en;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = en ? LOAD : IDLE;
                    pend_nxt  = en ? 1'b0 : pending;
                end
                LOAD: begin
                    count_nxt = preset;
                    psc_nxt   = '0;
                    state_nxt = CNT;
                end
                CNT: begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (psc_cnt == psc) begin
                        psc_nxt   = '0;
                        count_nxt = count > CW'(1) ? count - CW'(1) : '0;
                        pend_nxt  = count > CW'(1) ? pending : 1'b1;
                        state_nxt = count > CW'(1) ? CNT : DONE;
                    end else begin
                        psc_nxt = psc_cnt + PSC_W'(1);
                    end
                end
                DONE: begin
                    state_nxt = mode == M_ONESHOT ? IDLE : LOAD;
                    en_nxt    = mode == M_ONESHOT ? 1'b0 : en;
                end
            endcase
        end
    end

    // register file and state update
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            en      <= 1'b0;
            mode    <= M_ONESHOT;
            ie      <= 1'b0;
            psc     <= '0;
            preset  <= '0;
            cmp     <= '0;
            count   <= '0;
            psc_cnt <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            en      <= en_nxt;
            count   <= count_nxt;
            psc_cnt <= psc_nxt;
            pending <= pend_nxt;
            if (we && off == OFF_CTRL) begin
                mode <= mode_t'(din[CTRL_MODE +: 2]);
                ie   <= din[CTRL_IE];
                psc  <= din[CTRL_PSC +: PSC_W];
            end
            if (we && off == OFF_PRESET) preset <= din[CW-1:0];
            if (we && off == OFF_CMP) cmp <= din[CW-1:0];
        end
    end

    assign irq  = ie & pending;
    assign pwm  = mode == M_PWM && en && state == CNT && count <= cmp;
    assign dout = off == OFF_CTRL   ? 32'({psc, ie, mode, en}) :
                  off == OFF_PRESET ? 32'(preset) :
                  off == OFF_COUNT  ? 32'(count) :
                  off == OFF_CMP    ? 32'(cmp) :
                  off == OFF_STATUS ? 32'(pending) : 32'd0;
endmodule

// File: rtl/multi_timer.sv
// multi_timer: NCH independent timer channels behind one word-addressed register window
module multi_timer
    import timer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [29:0]    Addr,
    input  logic           WE,
    input  logic [31:0]    Din,
    output logic [31:0]    Dout,
    output logic           IRQ,
    output logic [NCH-1:0] irq_vec,
    output logic [NCH-1:0] pwm_out
);
    localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;

    // Addr is a word address: byte bits [4:2] are Addr[2:0], the channel starts at Addr[3]
    logic [2:0]     off;
    logic [CHW-1:0] chan;
    logic           hit, wr_ok;
    logic [31:0]    rd [NCH];

    assign off   = Addr[2:0];
    assign chan  = Addr[3 +: CHW];
    assign hit   = Addr[29:3+CHW] == '0 && 32'(chan) < NCH;
    assign wr_ok = WE && hit && off <= OFF_STATUS;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(.CW(CW)) u_ch (
            .clk  (clk),
            .reset(reset),
            .we   (wr_ok && chan == CHW'(g)),
            .off  (off),
            .din  (Din),
            .dout (rd[g]),
            .irq  (irq_vec[g]),
            .pwm  (pwm_out[g])
        );
    end

    // read mux; unmapped channels read zero
    always_comb begin
        Dout = '0;
        for (int i = 0; i < NCH; i++) Dout = (hit && chan == CHW'(i)) ? rd[i] : Dout;
    end

    assign IRQ = |irq_vec;
endmodule
